config_word_arbiter: RTL and testbench
======================================

// Module: config_word_arbiter
// PURPOSE
//  Shares the single fabric configuration word port (word_write_strobe/write_data) between the
//  USB DFU config path and the UART config path. Grants one source per bitstream session, holds
//  the grant until that session ends, and drops and flags words from the non-granted source.
//  Sits between the config_usb / UART config front-ends and the fabric frame-write logic.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  idle cycles (granted source inactive, no strobe) before the grant is released
//  CNT_WIDTH       24    width of the accepted/dropped word counters (saturating)
// PORTS
//  clk_i                input   1          system clock
//  reset_n_i            input   1          reset, synchronous, active-low
//  usb_active_i         input   1          USB session in progress (DFU bitstream alt selected)
//  usb_strobe_i         input   1          USB word valid, 1-cycle pulse
//  usb_data_i           input   32         USB config word
//  uart_active_i        input   1          UART session in progress
//  uart_strobe_i        input   1          UART word valid, 1-cycle pulse
//  uart_data_i          input   32         UART config word
//  clear_i              input   1          clears collision_o and both counters
//  word_write_strobe_o  output  1          word valid to fabric, 1-cycle pulse
//  write_data_o         output  32         word to fabric
//  grant_o              output  2          one-hot grant: [0] = USB, [1] = UART; 00 = idle
//  collision_o          output  1          sticky: a non-granted word was dropped
//  word_count_o         output  CNT_WIDTH  words forwarded this session (saturating)
//  drop_count_o         output  CNT_WIDTH  words dropped since clear (saturating)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low. While reset_n_i=0 at a clock edge, all
//    outputs go to 0, the FSM goes to IDLE and last_grant is set to UART (USB wins the first tie).
//    Reset mid-session aborts the grant; no strobe is emitted in the cycle after reset.
//  - req_x = x_active_i | x_strobe_i.
//  - FSM states: IDLE, GRANT_USB, GRANT_UART.
//    IDLE: if only one req, grant it. If both, round-robin: grant the source != last_grant.
//    GRANT_X: hold while req_x. When req_x=0 for TIMEOUT_CYCLES consecutive cycles, go to IDLE
//    and set last_grant := X.
//  - Timeout counter: cleared on any cycle with req_x=1; the release fires on the cycle the count
//    reaches TIMEOUT_CYCLES. A granted strobe arriving on that cycle cancels the release.
//  - Forwarding latency is 1 cycle, registered. A strobe from the granted source (including the
//    winner's strobe in the IDLE grant cycle) gives word_write_strobe_o=1 and write_data_o=data on
//    the next cycle, and word_count_o +1. write_data_o holds its last value otherwise.
//  - Drop: a strobe from the non-granted source (including the IDLE loser) is not forwarded.
//    It sets collision_o next cycle and increments drop_count_o. The granted word still passes.
//  - word_count_o resets to 0 on every new grant from IDLE. Counters saturate at all-ones.
//  - clear_i: collision_o and drop_count_o go to 0 next cycle; word_count_o is also cleared.
//    A drop in the same cycle as clear_i wins: collision_o=1, drop_count_o=1.
//  - grant_o is registered, reflects the state and is never 11.
// STRUCTURE
//  - Package config_arb_pkg holds: state enum localparams (IDLE=2'd0, GRANT_USB=2'd1,
//    GRANT_UART=2'd2), source indices SRC_USB=0 and SRC_UART=1, and the grant encodings.
//  - Sub-module config_arb_timeout: loadable up-counter of width $clog2(TIMEOUT_CYCLES+1).
//    Inputs clear and enable; output expired.
//  - Top: FSM, round-robin pointer, output mux/register, saturating counters.
// TESTING
//  1. USB only: usb_active_i=1 and 4 strobes of 0x0000_00AA..0x0000_00AD.
//     -> grant_o=01, 4 output strobes each 1 cycle late with matching data, word_count_o=4.
//  2. Simultaneous first request: both active on the same cycle after reset.
//     -> grant_o=01. After USB releases and times out, UART is granted (round-robin).
//  3. Collision: USB granted, UART strobe 0xDEAD_BEEF.
//     -> no output strobe, collision_o=1, drop_count_o=1. clear_i -> both 0 next cycle.
//  4. Timeout edge: USB inactive for TIMEOUT_CYCLES-1 cycles, then a strobe -> grant held.
//     Inactive for exactly TIMEOUT_CYCLES -> grant_o=00.
//  5. Reset mid-session: reset_n_i=0 for one cycle after 2 USB words.
//     -> all outputs 0, grant_o=00. UART alone then gets the grant.
//  6. Saturation: force counters near max (CNT_WIDTH=4 build); 20 strobes -> word_count_o=15.

Source files
------------

// File: rtl/config_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : config_arb_pkg
//  Description : Shared constants for the configuration word arbiter:
//                FSM state encodings, source indices, one-hot grant
//                encodings and a state-to-grant decode helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package config_arb_pkg;

    // FSM state encodings
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] GRANT_USB  = 2'd1;
    localparam logic [1:0] GRANT_UART = 2'd2;

    // Source indices, also used as the round-robin "last granted" value
    localparam logic SRC_USB  = 1'b0;
    localparam logic SRC_UART = 1'b1;

    // One-hot grant encodings as seen on grant_o
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_USB  = 2'b01;
    localparam logic [1:0] GNT_UART = 2'b10;

    // Grant seen by the outside world for a given FSM state; any unused
    // state encoding decodes to "no grant" so grant_o can never be 11.
    function automatic logic [1:0] grant_of_state(input logic [1:0] state);
        logic [1:0] gnt;
        case (state)
            GRANT_USB:  gnt = GNT_USB;
            GRANT_UART: gnt = GNT_UART;
            default:    gnt = GNT_NONE;
        endcase
        return gnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/config_arb_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : config_arb_timeout
//  Description : Idle-release timer. Counts consecutive enabled cycles and
//                flags expiry combinationally on the cycle that would be the
//                TIMEOUT_CYCLES-th one, so the owner can leave its grant on
//                that same clock edge.
//  Ports       : clk_i      - system clock
//                reset_n_i  - synchronous active-low reset
//                clear_i    - reload the count with zero
//                enable_i   - count this cycle (granted source inactive)
//                expired_o  - this cycle completes TIMEOUT_CYCLES idle cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module config_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    // r_count holds the number of idle cycles already completed; expiry is
    // therefore signalled when it equals TIMEOUT_CYCLES-1 and one more idle
    // cycle is in progress.
    localparam logic [CW-1:0] c_last = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] c_max  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (enable_i && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired_o = enable_i && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/config_word_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : config_word_arbiter
//  Description : Shares the fabric configuration word port between the USB
//                DFU and UART config paths. One source owns the port per
//                bitstream session (round-robin on ties), the grant is held
//                until that source goes quiet for TIMEOUT_CYCLES, and words
//                from the other source are dropped and flagged.
//  Ports       : clk_i, reset_n_i        - clock, synchronous active-low reset
//                usb_active_i/strobe_i/data_i   - USB session, word pulse, word
//                uart_active_i/strobe_i/data_i  - UART session, word pulse, word
//                clear_i                 - clear collision and both counters
//                word_write_strobe_o     - word valid to fabric (1 cycle)
//                write_data_o            - word to fabric (held between words)
//                grant_o                 - one-hot grant [0]=USB [1]=UART
//                collision_o             - sticky, a non-granted word was dropped
//                word_count_o            - words forwarded this session (sat.)
//                drop_count_o            - words dropped since clear (sat.)
//  Revision    : 1.0 - initial release
// ============================================================================
module config_word_arbiter
    import config_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 24
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 usb_active_i,
    input  logic                 usb_strobe_i,
    input  logic [31:0]          usb_data_i,
    input  logic                 uart_active_i,
    input  logic                 uart_strobe_i,
    input  logic [31:0]          uart_data_i,
    input  logic                 clear_i,
    output logic                 word_write_strobe_o,
    output logic [31:0]          write_data_o,
    output logic [1:0]           grant_o,
    output logic                 collision_o,
    output logic [CNT_WIDTH-1:0] word_count_o,
    output logic [CNT_WIDTH-1:0] drop_count_o
);

    // ------------------------------------------------------------------
    // Requests and registered state
    // ------------------------------------------------------------------
    logic w_req_usb;
    logic w_req_uart;

    assign w_req_usb  = usb_active_i  | usb_strobe_i;
    assign w_req_uart = uart_active_i | uart_strobe_i;

    logic [1:0]           r_state;
    logic                 r_last_grant;
    logic [1:0]           r_grant;
    logic                 r_strobe;
    logic [31:0]          r_data;
    logic                 r_collision;
    logic [CNT_WIDTH-1:0] r_word_count;
    logic [CNT_WIDTH-1:0] r_drop_count;

    // ------------------------------------------------------------------
    // Idle-release timer: runs only while a source is granted and that
    // source neither holds active nor strobes.
    // ------------------------------------------------------------------
    logic w_tmo_enable;
    logic w_tmo_expired;

    assign w_tmo_enable = ((r_state == GRANT_USB)  && !w_req_usb) ||
                          ((r_state == GRANT_UART) && !w_req_uart);

    config_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (!w_tmo_enable),
        .enable_i  (w_tmo_enable),
        .expired_o (w_tmo_expired)
    );

    // ------------------------------------------------------------------
    // Round-robin tie break from IDLE: with both requesting, the source
    // that did not own the previous session wins.
    // ------------------------------------------------------------------
    logic w_win_usb;
    logic w_win_uart;

    assign w_win_usb  = w_req_usb && (!w_req_uart || (r_last_grant == SRC_UART));
    assign w_win_uart = w_req_uart && !w_win_usb;

    // ------------------------------------------------------------------
    // Next-state, forward and drop decode
    // ------------------------------------------------------------------
    logic [1:0] w_state_next;
    logic       w_last_grant_next;
    logic       w_fwd_valid;
    logic       w_fwd_src;
    logic       w_drop;
    logic       w_new_grant;

    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_fwd_valid       = 1'b0;
        w_fwd_src         = SRC_USB;
        w_drop            = 1'b0;
        w_new_grant       = 1'b0;

        case (r_state)
            IDLE: begin
                // The winner's strobe in the grant cycle is already forwarded;
                // the loser's strobe in that cycle is a drop.
                if (w_win_usb) begin
                    w_state_next = GRANT_USB;
                    w_new_grant  = 1'b1;
                    w_fwd_valid  = usb_strobe_i;
                    w_fwd_src    = SRC_USB;
                    w_drop       = uart_strobe_i;
                end else if (w_win_uart) begin
                    w_state_next = GRANT_UART;
                    w_new_grant  = 1'b1;
                    w_fwd_valid  = uart_strobe_i;
                    w_fwd_src    = SRC_UART;
                    w_drop       = usb_strobe_i;
                end
            end
            GRANT_USB: begin
                w_fwd_valid = usb_strobe_i;
                w_fwd_src   = SRC_USB;
                w_drop      = uart_strobe_i;
                // A granted strobe keeps the timer disabled, so it can never
                // coincide with a release.
                if (w_tmo_expired) begin
                    w_state_next      = IDLE;
                    w_last_grant_next = SRC_USB;
                end
            end
            GRANT_UART: begin
                w_fwd_valid = uart_strobe_i;
                w_fwd_src   = SRC_UART;
                w_drop      = usb_strobe_i;
                if (w_tmo_expired) begin
                    w_state_next      = IDLE;
                    w_last_grant_next = SRC_UART;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counter updates. Clearing (or a new session) zeroes the base first,
    // so an event in the same cycle still counts as the first one.
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] w_wc_base;
    logic [CNT_WIDTH-1:0] w_wc_next;
    logic [CNT_WIDTH-1:0] w_dc_base;
    logic [CNT_WIDTH-1:0] w_dc_next;

    always_comb begin
        w_wc_base = (clear_i || w_new_grant) ? '0 : r_word_count;
        w_wc_next = w_wc_base;
        if (w_fwd_valid && (w_wc_base != '1)) begin
            w_wc_next = w_wc_base + 1'b1;
        end

        w_dc_base = clear_i ? '0 : r_drop_count;
        w_dc_next = w_dc_base;
        if (w_drop && (w_dc_base != '1)) begin
            w_dc_next = w_dc_base + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state      <= IDLE;
            r_last_grant <= SRC_UART;
            r_grant      <= GNT_NONE;
            r_strobe     <= 1'b0;
            r_data       <= '0;
            r_collision  <= 1'b0;
            r_word_count <= '0;
            r_drop_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
            r_grant      <= grant_of_state(w_state_next);
            r_strobe     <= w_fwd_valid;
            if (w_fwd_valid) begin
                r_data <= (w_fwd_src == SRC_UART) ? uart_data_i : usb_data_i;
            end
            r_collision  <= (r_collision && !clear_i) || w_drop;
            r_word_count <= w_wc_next;
            r_drop_count <= w_dc_next;
        end
    end

    assign word_write_strobe_o = r_strobe;
    assign write_data_o        = r_data;
    assign grant_o             = r_grant;
    assign collision_o         = r_collision;
    assign word_count_o        = r_word_count;
    assign drop_count_o        = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_config_word_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_config_word_arbiter
//  Description : Directed self-checking bench for config_word_arbiter,
//                built with a short timeout and 4-bit counters so that
//                release timing and saturation are reachable quickly.
//  Ports       : none (testbench)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_config_word_arbiter;

    localparam int T_CYC = 16;
    localparam int CW    = 4;

    logic          clk;
    logic          reset_n;
    logic          usb_active;
    logic          usb_strobe;
    logic [31:0]   usb_data;
    logic          uart_active;
    logic          uart_strobe;
    logic [31:0]   uart_data;
    logic          clear;
    logic          w_strobe;
    logic [31:0]   w_data;
    logic [1:0]    w_grant;
    logic          w_collision;
    logic [CW-1:0] w_word_count;
    logic [CW-1:0] w_drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    config_word_arbiter #(
        .TIMEOUT_CYCLES (T_CYC),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n),
        .usb_active_i        (usb_active),
        .usb_strobe_i        (usb_strobe),
        .usb_data_i          (usb_data),
        .uart_active_i       (uart_active),
        .uart_strobe_i       (uart_strobe),
        .uart_data_i         (uart_data),
        .clear_i             (clear),
        .word_write_strobe_o (w_strobe),
        .write_data_o        (w_data),
        .grant_o             (w_grant),
        .collision_o         (w_collision),
        .word_count_o        (w_word_count),
        .drop_count_o        (w_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic strobe, input logic [31:0] data,
                                 input logic [1:0] grant, input logic coll,
                                 input int wc, input int dc);
        check_eq({tag, ".strobe"}, 32'(w_strobe), 32'(strobe));
        check_eq({tag, ".data"},   w_data, data);
        check_eq({tag, ".grant"},  32'(w_grant), 32'(grant));
        check_eq({tag, ".coll"},   32'(w_collision), 32'(coll));
        check_eq({tag, ".wcnt"},   32'(w_word_count), 32'(wc));
        check_eq({tag, ".dcnt"},   32'(w_drop_count), 32'(dc));
    endtask

    initial begin
        reset_n     = 1'b0;
        usb_active  = 1'b0;
        usb_strobe  = 1'b0;
        usb_data    = '0;
        uart_active = 1'b0;
        uart_strobe = 1'b0;
        uart_data   = '0;
        clear       = 1'b0;

        // Reset state
        tick(2);
        check_outputs("reset", 1'b0, 32'h0, 2'b00, 1'b0, 0, 0);

        // 1. USB only, four words, one cycle forwarding latency
        reset_n    = 1'b1;
        usb_active = 1'b1;
        tick(1);
        check_eq("usb_grant", 32'(w_grant), 32'h1);
        for (int i = 0; i < 4; i++) begin
            usb_strobe = 1'b1;
            usb_data   = 32'h0000_00AA + 32'(i);
            tick(1);
            check_eq("usb_fwd_strobe", 32'(w_strobe), 32'h1);
            check_eq("usb_fwd_data", w_data, 32'h0000_00AA + 32'(i));
            usb_strobe = 1'b0;
            tick(1);
            check_eq("usb_strobe_low", 32'(w_strobe), 32'h0);
        end
        check_eq("usb_word_count", 32'(w_word_count), 32'd4);

        // 4. Timeout edge: a strobe on the last idle cycle holds the grant
        usb_active = 1'b0;
        tick(T_CYC - 1);
        check_eq("tmo_hold_before", 32'(w_grant), 32'h1);
        usb_strobe = 1'b1;
        usb_data   = 32'h0000_0055;
        tick(1);
        usb_strobe = 1'b0;
        check_outputs("tmo_cancel", 1'b1, 32'h55, 2'b01, 1'b0, 5, 0);
        tick(T_CYC - 1);
        check_eq("tmo_not_yet", 32'(w_grant), 32'h1);
        tick(1);
        check_eq("tmo_release", 32'(w_grant), 32'h0);
        check_eq("tmo_wcnt_kept", 32'(w_word_count), 32'd5);

        // 2. Simultaneous first request after reset: USB first, then UART
        reset_n = 1'b0;
        tick(1);
        reset_n     = 1'b1;
        usb_active  = 1'b1;
        uart_active = 1'b1;
        tick(1);
        check_eq("tie_first_usb", 32'(w_grant), 32'h1);
        usb_active = 1'b0;
        tick(T_CYC);
        check_eq("tie_usb_released", 32'(w_grant), 32'h0);
        tick(1);
        check_eq("tie_rr_uart", 32'(w_grant), 32'h2);

        // 3. Collision while USB granted, then clear
        uart_active = 1'b0;
        tick(T_CYC);
        check_eq("uart_released", 32'(w_grant), 32'h0);
        usb_active = 1'b1;
        tick(1);
        check_outputs("coll_grant", 1'b0, 32'h0, 2'b01, 1'b0, 0, 0);
        uart_strobe = 1'b1;
        uart_data   = 32'hDEAD_BEEF;
        tick(1);
        check_outputs("coll_drop", 1'b0, 32'h0, 2'b01, 1'b1, 0, 1);
        usb_strobe = 1'b1;
        usb_data   = 32'h0000_0011;
        tick(1);
        usb_strobe  = 1'b0;
        uart_strobe = 1'b0;
        check_outputs("coll_both", 1'b1, 32'h11, 2'b01, 1'b1, 1, 2);
        clear = 1'b1;
        tick(1);
        check_outputs("clear", 1'b0, 32'h11, 2'b01, 1'b0, 0, 0);
        uart_strobe = 1'b1;
        tick(1);
        clear       = 1'b0;
        uart_strobe = 1'b0;
        check_outputs("clear_vs_drop", 1'b0, 32'h11, 2'b01, 1'b1, 0, 1);

        // 5. Reset mid-session after two USB words
        usb_strobe = 1'b1;
        usb_data   = 32'h0000_0101;
        tick(1);
        check_eq("mid_w1", w_data, 32'h101);
        usb_data = 32'h0000_0102;
        tick(1);
        check_outputs("mid_w2", 1'b1, 32'h102, 2'b01, 1'b1, 2, 1);
        reset_n  = 1'b0;
        usb_data = 32'h0000_0103;
        tick(1);
        check_outputs("mid_reset", 1'b0, 32'h0, 2'b00, 1'b0, 0, 0);
        reset_n     = 1'b1;
        usb_strobe  = 1'b0;
        usb_active  = 1'b0;
        uart_active = 1'b1;
        tick(1);
        check_eq("post_reset_uart", 32'(w_grant), 32'h2);

        // 6. Saturation: 20 granted UART words and 20 dropped USB words
        for (int i = 0; i < 20; i++) begin
            uart_strobe = 1'b1;
            usb_strobe  = 1'b1;
            uart_data   = 32'h0000_1000 + 32'(i);
            tick(1);
            if (i == 13) check_eq("sat_wcnt_14", 32'(w_word_count), 32'd14);
        end
        uart_strobe = 1'b0;
        usb_strobe  = 1'b0;
        check_outputs("saturate", 1'b1, 32'h1013, 2'b10, 1'b1, 15, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
